jk_mod_counter: RTL and testbench

- Parametrised modulo-M synchronous up/down counter whose state bits are held in JK flip-flops; the next state is converted into per-bit J/K drives.
- Generalises the lab mod-8 JK counter to arbitrary width and modulus.
- Adds direction control, synchronous load/clear, enable, wrap-or-saturate mode, terminal-count and wrap/done flags.
- Sits as a reusable timing/sequence counter in lab designs, such as dividers and display scanners.

---
 rtl/jk_mod_counter_pkg.sv | 16 +
 rtl/jk_mod_counter_if.sv | 26 ++
 rtl/jk_mod_counter_jk_ff_ar.sv | 27 ++
 rtl/jk_mod_counter.sv | 118 +++++++++++
 tb/tb_jk_mod_counter.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/jk_mod_counter_pkg.sv
// Shared constants and helpers for the JK-flip-flop modulo counter.
package jk_mod_counter_pkg;

  // J/K drive encodings, written as {J, K}.
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

  // True when the WIDTH/MODULUS pair describes a buildable counter.
  function automatic bit params_legal(input int width, input int modulus);
    return (width >= 32'sd1) && (width <= 32'sd16) &&
           (modulus >= 32'sd2) && (modulus <= (32'sd1 << width));
  endfunction

endpackage

// File: rtl/jk_mod_counter_if.sv
// Control/status bundle of the modulo counter; the master drives the controls.
interface jk_mod_counter_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             dir;
  logic             sat;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             done;
  logic             load_err;

  modport master (
    output en, dir, sat, clr, load, load_val,
    input  q, tc, wrap, done, load_err
  );

  modport slave (
    input  en, dir, sat, clr, load, load_val,
    output q, tc, wrap, done, load_err
  );
endinterface

// File: rtl/jk_mod_counter_jk_ff_ar.sv
// Single JK flip-flop with asynchronous active-high reset.
module jk_ff_ar
  import jk_mod_counter_pkg::*;
(
  input  logic CLK,
  input  logic rst,
  input  logic J,
  input  logic K,
  output logic Q
);

  // JK state update: hold, reset, set or toggle on the rising edge.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      Q <= 1'b0;
    end else begin
      case ({J, K})
        JK_HOLD: Q <= Q;
        JK_RST:  Q <= 1'b0;
        JK_SET:  Q <= 1'b1;
        JK_TOG:  Q <= ~Q;
        default: Q <= Q;
      endcase
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter whose state bits live in JK flip-flops.
// Priority per edge is clr > load > en > hold; the end of range either
// wraps (with a one-cycle wrap pulse) or saturates (setting sticky done).
module jk_mod_counter
  import jk_mod_counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic               CLK,
  input  logic               rst,
  jk_mod_counter_if.slave    bus
);

  if (!params_legal(WIDTH, MODULUS)) begin : g_param_err
    $error("jk_mod_counter: WIDTH must be 1..16 and MODULUS 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_load_val;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_wrap_nxt;
  logic             w_done_nxt;
  logic             w_lerr_nxt;
  logic             r_wrap;
  logic             r_done;
  logic             r_load_err;

  assign w_load_val = bus.load_val;
  assign w_at_max   = (w_q == MAX_V);
  assign w_at_zero  = (w_q == ZERO_V);

  // Priority-resolved next count and next flag values.
  always_comb begin
    w_next     = w_q;
    w_wrap_nxt = 1'b0;
    w_lerr_nxt = 1'b0;
    w_done_nxt = r_done;
    if (bus.clr) begin
      w_next     = ZERO_V;
      w_done_nxt = 1'b0;
    end else if (bus.load) begin
      w_done_nxt = 1'b0;
      if (w_load_val <= MAX_V) begin
        w_next = w_load_val;
      end else begin
        // Out-of-range load clamps to the top of the range and flags it.
        w_next     = MAX_V;
        w_lerr_nxt = 1'b1;
      end
    end else if (bus.en) begin
      if (bus.dir) begin
        if (!w_at_max) begin
          w_next = WIDTH'({1'b0, w_q} + {{WIDTH{1'b0}}, 1'b1});
        end else if (bus.sat) begin
          w_done_nxt = 1'b1;
        end else begin
          w_next     = ZERO_V;
          w_wrap_nxt = 1'b1;
        end
      end else begin
        if (!w_at_zero) begin
          w_next = WIDTH'({1'b0, w_q} - {{WIDTH{1'b0}}, 1'b1});
        end else if (bus.sat) begin
          w_done_nxt = 1'b1;
        end else begin
          w_next     = MAX_V;
          w_wrap_nxt = 1'b1;
        end
      end
    end else begin
      w_next = w_q;
    end
  end

  // Convert the next value into per-bit J/K drives (never uses toggle).
  always_comb begin
    w_j = w_next & ~w_q;
    w_k = ~w_next & w_q;
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    jk_ff_ar u_ff (
      .CLK (CLK),
      .rst (rst),
      .J   (w_j[gi]),
      .K   (w_k[gi]),
      .Q   (w_q[gi])
    );
  end

  // Registered status flags: wrap/load_err pulses and sticky done.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_wrap     <= 1'b0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= w_wrap_nxt;
      r_done     <= w_done_nxt;
      r_load_err <= w_lerr_nxt;
    end
  end

  assign bus.q        = w_q;
  assign bus.tc       = (bus.dir & w_at_max) | (~bus.dir & w_at_zero);
  assign bus.wrap     = r_wrap;
  assign bus.done     = r_done;
  assign bus.load_err = r_load_err;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed self-checking bench for jk_mod_counter: a default mod-8 instance
// and a WIDTH=4 / MODULUS=10 instance share the clock and reset.
module tb_jk_mod_counter;

  logic CLK;
  logic rst;
  int   n_checks;
  int   n_errors;

  jk_mod_counter_if #(.WIDTH(3)) if8 ();
  jk_mod_counter_if #(.WIDTH(4)) if10 ();

  jk_mod_counter #(.WIDTH(3), .MODULUS(8)) u_dut8 (
    .CLK (CLK),
    .rst (rst),
    .bus (if8.slave)
  );

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_dut10 (
    .CLK (CLK),
    .rst (rst),
    .bus (if10.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    if8.en = 1'b0;  if8.dir = 1'b1;  if8.sat = 1'b0;
    if8.clr = 1'b0; if8.load = 1'b0; if8.load_val = 3'd0;
    if10.en = 1'b0;  if10.dir = 1'b1;  if10.sat = 1'b0;
    if10.clr = 1'b0; if10.load = 1'b0; if10.load_val = 4'd0;
    #12;
    check_eq("rst_q8", int'(if8.q), 0);
    check_eq("rst_wrap8", int'(if8.wrap), 0);
    check_eq("rst_done8", int'(if8.done), 0);
    check_eq("rst_lerr8", int'(if8.load_err), 0);
    tick();
    rst = 1'b0;

    // Mod-8 up count with wrap.
    if8.en = 1'b1; if8.dir = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_eq($sformatf("up8_q_%0d", i), int'(if8.q), i % 8);
      check_eq($sformatf("up8_wrap_%0d", i), int'(if8.wrap), (i == 8) ? 1 : 0);
      check_eq($sformatf("up8_tc_%0d", i), int'(if8.tc), ((i % 8) == 7) ? 1 : 0);
    end
    if8.en = 1'b0;

    // Mod-10 down count from 0 with wrap to 9.
    if10.en = 1'b1; if10.dir = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check_eq($sformatf("dn10_q_%0d", i), int'(if10.q), (20 - i) % 10);
      check_eq($sformatf("dn10_wrap_%0d", i), int'(if10.wrap),
               ((i == 1) || (i == 11)) ? 1 : 0);
    end
    if10.en = 1'b0;

    // Saturation at 9, reverse, then clear.
    if10.load = 1'b1; if10.load_val = 4'd7;
    tick();
    if10.load = 1'b0;
    check_eq("sat_load7", int'(if10.q), 7);
    if10.sat = 1'b1; if10.dir = 1'b1; if10.en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_eq($sformatf("sat_q_%0d", i), int'(if10.q), (i == 1) ? 8 : 9);
      check_eq($sformatf("sat_done_%0d", i), int'(if10.done), (i >= 3) ? 1 : 0);
      check_eq($sformatf("sat_wrap_%0d", i), int'(if10.wrap), 0);
    end
    if10.dir = 1'b0;
    tick();
    check_eq("sat_rev_q", int'(if10.q), 8);
    check_eq("sat_rev_done", int'(if10.done), 1);
    if10.en = 1'b0; if10.clr = 1'b1;
    tick();
    if10.clr = 1'b0;
    check_eq("clr_q", int'(if10.q), 0);
    check_eq("clr_done", int'(if10.done), 0);
    check_eq("tc_down_zero", int'(if10.tc), 1);
    if10.sat = 1'b0;

    // Loads: out of range, legal, and load beating en.
    if10.load = 1'b1; if10.load_val = 4'd12;
    tick();
    if10.load = 1'b0;
    check_eq("ld12_q", int'(if10.q), 9);
    check_eq("ld12_lerr", int'(if10.load_err), 1);
    tick();
    check_eq("ld12_q_hold", int'(if10.q), 9);
    check_eq("ld12_lerr_drop", int'(if10.load_err), 0);
    if10.load = 1'b1; if10.load_val = 4'd5;
    tick();
    check_eq("ld5_q", int'(if10.q), 5);
    check_eq("ld5_lerr", int'(if10.load_err), 0);
    if10.load_val = 4'd3; if10.en = 1'b1; if10.dir = 1'b1;
    tick();
    if10.load = 1'b0; if10.en = 1'b0;
    check_eq("ld_en_q", int'(if10.q), 3);

    // Build state on both counters, then reset between edges.
    if8.en = 1'b1; if8.dir = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    if8.en = 1'b0;
    check_eq("pre_rst_q8", int'(if8.q), 6);
    if10.load = 1'b1; if10.load_val = 4'd9;
    tick();
    if10.load = 1'b0; if10.sat = 1'b1; if10.en = 1'b1;
    tick();
    if10.en = 1'b0; if10.sat = 1'b0;
    check_eq("pre_rst_done10", int'(if10.done), 1);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_q8", int'(if8.q), 0);
    check_eq("arst_q10", int'(if10.q), 0);
    check_eq("arst_done10", int'(if10.done), 0);
    check_eq("arst_wrap8", int'(if8.wrap), 0);
    check_eq("arst_lerr10", int'(if10.load_err), 0);
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_eq($sformatf("idle_q8_%0d", i), int'(if8.q), 0);
    end
    if8.en = 1'b1;
    tick();
    if8.en = 1'b0;
    check_eq("first_cnt_q8", int'(if8.q), 1);

    // clr, load and en together at q = 7.
    if8.load = 1'b1; if8.load_val = 3'd7;
    tick();
    check_eq("ld7_q8", int'(if8.q), 7);
    if8.clr = 1'b1; if8.load_val = 3'd5; if8.en = 1'b1; if8.dir = 1'b1;
    tick();
    if8.clr = 1'b0; if8.load = 1'b0; if8.en = 1'b0;
    check_eq("all_q8", int'(if8.q), 0);
    check_eq("all_wrap8", int'(if8.wrap), 0);
    check_eq("all_lerr8", int'(if8.load_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
